fuzzy_risk_seq: RTL and testbench

FUZZY_RISK_SEQ -- requirements
Module: fuzzy_risk_seq

---
 rtl/fuzzy_risk_seq.sv | 227 ++++++++++++++++++++++
 tb/tb_fuzzy_risk_seq.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fuzzy_risk_seq.sv
// Fuzzy flood-risk estimator: triangular memberships on rain/soil, three rules,
// weighted-average defuzzification through a sequential restoring divider.
module fuzzy_risk_seq #(
   parameter int W     = 8,
   parameter int LO_A  = 0,
   parameter int LO_B  = 20,
   parameter int LO_C  = 40,
   parameter int MD_A  = 30,
   parameter int MD_B  = 50,
   parameter int MD_C  = 70,
   parameter int HI_A  = 60,
   parameter int HI_B  = 80,
   parameter int HI_C  = 100,
   parameter int WT_LO = 85,
   parameter int WT_MD = 170,
   parameter int WT_HI = 255,
   parameter int TNORM = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] rain,
   input  logic [W-1:0] soil,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] risk,
   output logic         nofire,
   output logic         busy
);

   localparam int FULL = (1 << W) - 1;
   localparam int Q    = 2 * W + 2;
   localparam int CW   = $clog2(Q);

   localparam logic [W-1:0]     P_LO_A   = W'(LO_A);
   localparam logic [W-1:0]     P_LO_B   = W'(LO_B);
   localparam logic [W-1:0]     P_LO_C   = W'(LO_C);
   localparam logic [W-1:0]     P_MD_A   = W'(MD_A);
   localparam logic [W-1:0]     P_MD_B   = W'(MD_B);
   localparam logic [W-1:0]     P_MD_C   = W'(MD_C);
   localparam logic [W-1:0]     P_HI_A   = W'(HI_A);
   localparam logic [W-1:0]     P_HI_B   = W'(HI_B);
   localparam logic [W-1:0]     P_HI_C   = W'(HI_C);
   localparam logic [2*W-1:0]   P_FULL2  = (2*W)'(FULL);
   localparam logic [Q-1:0]     P_FULLQ  = Q'(FULL);
   localparam logic [2*W+1:0]   P_WT_LO  = (2*W+2)'(WT_LO);
   localparam logic [2*W+1:0]   P_WT_MD  = (2*W+2)'(WT_MD);
   localparam logic [2*W+1:0]   P_WT_HI  = (2*W+2)'(WT_HI);
   localparam logic [CW-1:0]    P_CNT_LAST = CW'(Q - 1);

   // Elaboration-time guards on the parameter set
   if (W < 4 || W > 16) begin : g_bad_w
      $error("fuzzy_risk_seq: W must be within 4..16");
   end
   if (!(LO_A < LO_B && LO_B < LO_C && LO_C <= FULL)) begin : g_bad_lo
      $error("fuzzy_risk_seq: low set breakpoints must satisfy a<b<c<=FULL");
   end
   if (!(MD_A < MD_B && MD_B < MD_C && MD_C <= FULL)) begin : g_bad_md
      $error("fuzzy_risk_seq: medium set breakpoints must satisfy a<b<c<=FULL");
   end
   if (!(HI_A < HI_B && HI_B < HI_C && HI_C <= FULL)) begin : g_bad_hi
      $error("fuzzy_risk_seq: high set breakpoints must satisfy a<b<c<=FULL");
   end
   if (WT_LO > FULL || WT_MD > FULL || WT_HI > FULL || WT_LO < 0 || WT_MD < 0 || WT_HI < 0) begin : g_bad_wt
      $error("fuzzy_risk_seq: rule weights must lie within 0..FULL");
   end
   if (TNORM != 0 && TNORM != 1) begin : g_bad_tn
      $error("fuzzy_risk_seq: TNORM must be 0 (min) or 1 (product)");
   end

   typedef enum logic [1:0] {S_IDLE, S_FUZZ, S_DIV, S_DONE} state_t;

   function automatic logic [W-1:0] f_mu(input logic [W-1:0] v,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic [W-1:0] c);
      logic [2*W-1:0] x;
      logic [2*W-1:0] span;
      x    = '0;
      span = '1;
      f_mu = '0;
      if (v <= a) begin
         f_mu = '0;
      end else if (v <= b) begin
         x    = (2*W)'(v - a);
         span = (2*W)'(b - a);
         f_mu = W'((x * P_FULL2) / span);
      end else if (v <= c) begin
         x    = (2*W)'(c - v);
         span = (2*W)'(c - b);
         f_mu = W'((x * P_FULL2) / span);
      end
   endfunction

   function automatic logic [W-1:0] f_tn(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [2*W-1:0] p;
      p = (2*W)'(x) * (2*W)'(y);
      if (TNORM == 0) f_tn = (x < y) ? x : y;
      else            f_tn = W'(p >> W);
   endfunction

   state_t          r_state;
   logic            r_in_ready;
   logic            r_busy;
   logic            r_out_valid;
   logic [W-1:0]    r_risk;
   logic            r_nofire;
   logic [W-1:0]    r_rain;
   logic [W-1:0]    r_soil;
   logic [2*W+1:0]  r_num;
   logic [W+1:0]    r_den;
   logic [W+1:0]    r_rem;
   logic [Q-2:0]    r_quo;
   logic [CW-1:0]   r_cnt;

   logic [W-1:0]    w_rain_lo, w_rain_md, w_rain_hi;
   logic [W-1:0]    w_soil_lo, w_soil_md, w_soil_hi;
   logic [W-1:0]    w_s_lo, w_s_md, w_s_hi;
   logic [2*W+1:0]  w_num;
   logic [W+1:0]    w_den;
   logic [W+2:0]    w_rem_sh;
   logic [W+2:0]    w_rem_diff;
   logic            w_ge;
   logic [W+1:0]    w_rem_nx;
   logic [Q-1:0]    w_quo_nx;

   always_comb begin
      w_rain_lo = f_mu(r_rain, P_LO_A, P_LO_B, P_LO_C);
      w_rain_md = f_mu(r_rain, P_MD_A, P_MD_B, P_MD_C);
      w_rain_hi = f_mu(r_rain, P_HI_A, P_HI_B, P_HI_C);
      w_soil_lo = f_mu(r_soil, P_LO_A, P_LO_B, P_LO_C);
      w_soil_md = f_mu(r_soil, P_MD_A, P_MD_B, P_MD_C);
      w_soil_hi = f_mu(r_soil, P_HI_A, P_HI_B, P_HI_C);
      w_s_lo    = f_tn(w_rain_lo, w_soil_lo);
      w_s_md    = f_tn(w_rain_md, w_soil_md);
      w_s_hi    = f_tn(w_rain_hi, w_soil_hi);
      w_num     = (2*W+2)'(w_s_hi) * P_WT_HI
                + (2*W+2)'(w_s_md) * P_WT_MD
                + (2*W+2)'(w_s_lo) * P_WT_LO;
      w_den     = (W+2)'(w_s_hi) + (W+2)'(w_s_md) + (W+2)'(w_s_lo);
   end

   // One restoring step: remainder stays below DEN, so W+2 bits always hold it
   always_comb begin
      w_rem_sh   = {r_rem, r_num[2*W+1]};
      w_rem_diff = w_rem_sh - {1'b0, r_den};
      w_ge       = (w_rem_sh >= {1'b0, r_den});
      w_rem_nx   = w_ge ? (W+2)'(w_rem_diff) : (W+2)'(w_rem_sh);
      w_quo_nx   = {r_quo, w_ge};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b1;
         r_busy      <= 1'b0;
         r_out_valid <= 1'b0;
         r_risk      <= '0;
         r_nofire    <= 1'b0;
         r_rain      <= '0;
         r_soil      <= '0;
         r_num       <= '0;
         r_den       <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_cnt       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_rain     <= rain;
                  r_soil     <= soil;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= S_FUZZ;
               end
            end
            S_FUZZ: begin
               r_num <= w_num;
               r_den <= w_den;
               r_rem <= '0;
               r_quo <= '0;
               r_cnt <= '0;
               if (w_den == '0) begin
                  r_risk      <= '0;
                  r_nofire    <= 1'b1;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_state <= S_DIV;
               end
            end
            S_DIV: begin
               r_num <= {r_num[2*W:0], 1'b0};
               r_rem <= w_rem_nx;
               r_quo <= w_quo_nx[Q-2:0];
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == P_CNT_LAST) begin
                  r_risk      <= (w_quo_nx > P_FULLQ) ? '1 : w_quo_nx[W-1:0];
                  r_nofire    <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign busy      = r_busy;
   assign out_valid = r_out_valid;
   assign risk      = r_risk;
   assign nofire    = r_nofire;

endmodule

// File: tb/tb_fuzzy_risk_seq.sv
// Directed-vector bench for fuzzy_risk_seq at W=8 with default parameters.
module tb_fuzzy_risk_seq;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] rain;
   logic [7:0] soil;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] risk;
   logic       nofire;
   logic       busy;

   int n_vec;
   int n_err;

   fuzzy_risk_seq #(.W(8), .TNORM(0)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .rain     (rain),
      .soil     (soil),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .risk     (risk),
      .nofire   (nofire),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // lat is the cycle count from acceptance cycle T to the first out_valid cycle
   task automatic run_vec(input logic [7:0] r, input logic [7:0] s,
                          input logic [7:0] exp_risk, input logic exp_nofire,
                          input int lat, input bit hold);
      int n;
      chk("in_ready_idle", in_ready, 1);
      rain     = r;
      soil     = s;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rain     = ~r;
      soil     = ~s;
      n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("latency", n, lat - 1);
      chk("risk", risk, exp_risk);
      chk("nofire", nofire, exp_nofire);
      chk("busy_done", busy, 1);
      chk("in_ready_done", in_ready, 0);
      if (hold) begin
         for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            rain     = 8'($urandom_range(0, 255));
            soil     = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
            chk("hold_risk", risk, exp_risk);
            chk("hold_out_valid", out_valid, 1);
         end
         in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("ov_after_hs", out_valid, 0);
      chk("in_ready_after_hs", in_ready, 1);
      chk("busy_after_hs", busy, 0);
   endtask

   initial begin
      int seen;
      n_vec     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rain      = '0;
      soil      = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_risk", risk, 0);
      chk("rst_nofire", nofire, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_vec(8'd20,  8'd20,  8'd85,  1'b0, 20, 1'b0);
      run_vec(8'd50,  8'd50,  8'd170, 1'b0, 20, 1'b0);
      run_vec(8'd80,  8'd80,  8'd255, 1'b0, 20, 1'b0);
      run_vec(8'd35,  8'd35,  8'd127, 1'b0, 20, 1'b1);
      run_vec(8'd200, 8'd200, 8'd0,   1'b1, 2,  1'b0);
      run_vec(8'd10,  8'd30,  8'd85,  1'b0, 20, 1'b0);
      run_vec(8'd65,  8'd65,  8'd212, 1'b0, 20, 1'b0);
      run_vec(8'd25,  8'd75,  8'd0,   1'b1, 2,  1'b0);
      run_vec(8'd80,  8'd80,  8'd255, 1'b0, 20, 1'b0);

      // Abort mid-division: accept at T, assert reset for the cycle T+8
      rain     = 8'd50;
      soil     = 8'd50;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      chk("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_risk", risk, 0);
      chk("mid_rst_busy", busy, 0);
      seen = 0;
      for (int k = 0; k < 25; k++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("mid_rst_no_result", seen, 0);

      run_vec(8'd20, 8'd20, 8'd85, 1'b0, 20, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
